uart_echo_fifo: RTL and testbench

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

---
 rtl/uart_echo_fifo.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: a UART receiver and transmitter joined by an RX FIFO.
// Received frames are pushed into the FIFO. In host mode the FIFO is drained
// through the rx_* stream, and the host feeds the transmitter through tx_*.
// In echo mode the transmitter drains the FIFO itself.
//
// Ports
//   clk_i, rst_ni       single clock, asynchronous active-low reset
//   rxd_i / txd_o       serial lines, both idle high
//   prescale_i          bit time = 8*prescale_i clocks (0 behaves as 1)
//   echo_en_i           1 = loop RX to TX, 0 = host mode
//   tx_data_i/valid/ready   host transmit stream
//   rx_data_o/valid/ready   host receive stream (FIFO head)
//   fifo_level_o        RX FIFO occupancy
//   overrun_o, frame_err_o  sticky error flags, cleared by clr_err_i
module uart_echo_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rxd_i,
  output logic                             txd_o,
  input  logic [15:0]                      prescale_i,
  input  logic                             echo_en_i,
  input  logic [DATA_WIDTH-1:0]            tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic [DATA_WIDTH-1:0]            rx_data_o,
  output logic                             rx_valid_o,
  input  logic                             rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             overrun_o,
  output logic                             frame_err_o,
  input  logic                             clr_err_i
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = 19;  // holds 8*65535-1
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // A prescale of zero would give a zero-length bit; treat it as one.
  function automatic logic [15:0] eff_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

  // Reload value for a full bit time (8*P cycles, counted down to zero).
  function automatic logic [CW-1:0] bit_reload(input logic [15:0] p);
    return {p, 3'b000} - 19'd1;
  endfunction

  // Reload value for half a bit (4*P cycles) to reach the start-bit centre.
  function automatic logic [CW-1:0] half_reload(input logic [15:0] p);
    return {1'b0, p, 2'b00} - 19'd1;
  endfunction

  logic [15:0] prescale_eff_s;
  assign prescale_eff_s = eff_prescale(prescale_i);

  // ---------------------------------------------------------------- RX sync
  logic [1:0] rx_sync_q;
  logic [1:0] rx_warm_q;
  logic       rx_prev_q;
  logic       rxd_s;
  logic       rx_fall_s;

  assign rxd_s     = rx_sync_q[1];
  // rx_prev_q only becomes 1 once a real high level has left the synchroniser,
  // so a frame already in flight at reset release is never mistaken for a start.
  assign rx_fall_s = rx_prev_q & ~rxd_s;

  // Two-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;
      rx_warm_q <= 2'b00;
      rx_prev_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rxd_i};
      rx_warm_q <= {rx_warm_q[0], 1'b1};
      rx_prev_q <= rx_warm_q[1] & rxd_s;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  state_e                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [15:0]           rx_p_q, rx_p_d;
  logic                  rx_push_q, rx_push_d;
  logic                  frame_err_evt_s;

  // RX next-state: centre-sample start, data (LSB first) and stop bits.
  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_p_d          = rx_p_q;
    rx_push_d       = 1'b0;
    frame_err_evt_s = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall_s) begin
          rx_p_d     = prescale_eff_s;
          rx_cnt_d   = half_reload(prescale_eff_s);
          rx_state_d = S_START;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_cnt_q != 19'd0) begin
          rx_cnt_d = rx_cnt_q - 19'd1;
        end else if (rxd_s) begin
          rx_state_d = S_IDLE;  // glitch, not a real start bit
        end else begin
          rx_state_d = S_DATA;
          rx_cnt_d   = bit_reload(rx_p_q);
          rx_bit_d   = '0;
        end
      end
      S_DATA: begin
        if (rx_cnt_q != 19'd0) begin
          rx_cnt_d = rx_cnt_q - 19'd1;
        end else begin
          rx_shift_d = {rxd_s, rx_shift_q[DATA_WIDTH-1:1]};
          rx_cnt_d   = bit_reload(rx_p_q);
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BW'(1);
          end
        end
      end
      S_STOP: begin
        if (rx_cnt_q != 19'd0) begin
          rx_cnt_d = rx_cnt_q - 19'd1;
        end else begin
          rx_state_d = S_IDLE;
          if (rxd_s) begin
            rx_push_d = 1'b1;
          end else begin
            frame_err_evt_s = 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_p_q     <= 16'd1;
      rx_push_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_p_q     <= rx_p_d;
      rx_push_q  <= rx_push_d;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  fifo_empty_s, fifo_full_s;
  logic                  host_pop_s, tx_pop_s, fifo_pop_s;
  logic                  fifo_push_ok_s, overrun_evt_s;

  assign fifo_empty_s   = (level_q == '0);
  assign fifo_full_s    = (level_q == LEVEL_FULL);
  assign rx_valid_o     = ~echo_en_i & ~fifo_empty_s;
  // The storage array is flop-based, so the head is presented straight from registers.
  assign rx_data_o      = fifo_mem_q[rd_ptr_q];
  assign host_pop_s     = rx_valid_o & rx_ready_i;
  assign fifo_pop_s     = host_pop_s | tx_pop_s;
  // A pop in the same cycle frees the slot the push needs.
  assign fifo_push_ok_s = rx_push_q & (~fifo_full_s | fifo_pop_s);
  assign overrun_evt_s  = rx_push_q & fifo_full_s & ~fifo_pop_s;
  assign fifo_level_o   = level_q;

  // FIFO occupancy next value.
  always_comb begin
    level_d = level_q;
    case ({fifo_push_ok_s, fifo_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fifo_pop_s)     rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // FIFO storage write (data path only, no reset needed).
  always_ff @(posedge clk_i) begin
    if (fifo_push_ok_s) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------------------------------------------------------- TX FSM
  state_e                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [15:0]           tx_p_q, tx_p_d;
  logic                  txd_q, txd_d;
  logic                  tx_alive_q;

  // tx_alive_q keeps tx_ready_o low while reset is asserted and for no longer.
  assign tx_ready_o = tx_alive_q & (tx_state_q == S_IDLE) & ~echo_en_i;
  assign txd_o      = txd_q;

  // TX next-state: mode is only looked at in IDLE, so a frame always completes.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_p_d     = tx_p_q;
    txd_d      = txd_q;
    tx_pop_s   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (echo_en_i && !fifo_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = rx_data_o;
          tx_p_d     = prescale_eff_s;
          tx_cnt_d   = bit_reload(prescale_eff_s);
          tx_state_d = S_START;
          txd_d      = 1'b0;
        end else if (tx_valid_i && tx_ready_o) begin
          tx_shift_d = tx_data_i;
          tx_p_d     = prescale_eff_s;
          tx_cnt_d   = bit_reload(prescale_eff_s);
          tx_state_d = S_START;
          txd_d      = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q != 19'd0) begin
          tx_cnt_d = tx_cnt_q - 19'd1;
        end else begin
          tx_state_d = S_DATA;
          tx_cnt_d   = bit_reload(tx_p_q);
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q != 19'd0) begin
          tx_cnt_d = tx_cnt_q - 19'd1;
        end else begin
          tx_cnt_d = bit_reload(tx_p_q);
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + BW'(1);
            tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q != 19'd0) begin
          tx_cnt_d = tx_cnt_q - 19'd1;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX state registers and the txd output flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_p_q     <= 16'd1;
      txd_q      <= 1'b1;
      tx_alive_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_p_q     <= tx_p_d;
      txd_q      <= txd_d;
      tx_alive_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- errors
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

  // Sticky flags: a new event beats a same-cycle clear.
  always_comb begin
    if (overrun_evt_s) begin
      overrun_d = 1'b1;
    end else if (clr_err_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (frame_err_evt_s) begin
      frame_err_d = 1'b1;
    end else if (clr_err_i) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo with scoreboard queues for the RX stream
// and for frames appearing on txd_o.
module tb_uart_echo_fifo;

  localparam int DW = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rxd_i;
  logic        txd_o;
  logic [15:0] prescale_i;
  logic        echo_en_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [4:0]  fifo_level_o;
  logic        overrun_o;
  logic        frame_err_o;
  logic        clr_err_i;

  int checks   = 0;
  int failures = 0;
  int bit_cyc  = 8;
  logic mon_en   = 1'b0;
  logic mon_busy = 1'b0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  always #5 clk_i = ~clk_i;

  uart_echo_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rxd_i(rxd_i), .txd_o(txd_o),
    .prescale_i(prescale_i), .echo_en_i(echo_en_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .fifo_level_o(fifo_level_o), .overrun_o(overrun_o),
    .frame_err_o(frame_err_o), .clr_err_i(clr_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive one serial frame onto rxd_i (called at a falling clock edge).
  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd_i = 1'b0;
    cycles(bit_cyc);
    for (int i = 0; i < DW; i++) begin
      rxd_i = d[i];
      cycles(bit_cyc);
    end
    rxd_i = stop;
    cycles(bit_cyc);
    rxd_i = 1'b1;
    cycles(2);
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    while (tx_ready_o !== 1'b1 && n < 2000) begin
      cycles(1);
      n++;
    end
    check("tx_accept", {31'd0, tx_ready_o}, 32'd1);
    cycles(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic read_rx();
    int n;
    logic [7:0] exp;
    n = 0;
    while (rx_valid_o !== 1'b1 && n < 2000) begin
      cycles(1);
      n++;
    end
    check("rx_valid", {31'd0, rx_valid_o}, 32'd1);
    if (exp_rx_q.size() != 0) begin
      exp = exp_rx_q.pop_front();
    end else begin
      exp = 8'hxx;
    end
    check("rx_data", {24'd0, rx_data_o}, {24'd0, exp});
    rx_ready_i = 1'b1;
    cycles(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic wait_tx_drain(input int limit);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || mon_busy) && n < limit) begin
      cycles(1);
      n++;
    end
    check("tx_drain", exp_tx_q.size(), 32'd0);
    check("tx_mon_idle", {31'd0, mon_busy}, 32'd0);
  endtask

  // Frame monitor: every txd_o sample of a frame must match the expected byte.
  initial begin : tx_mon
    logic [7:0] exp_b;
    int bad;
    forever begin
      @(negedge clk_i);
      if (mon_en && txd_o === 1'b0) begin
        mon_busy = 1'b1;
        check("tx_expected_frame", {31'd0, exp_tx_q.size() != 0}, 32'd1);
        if (exp_tx_q.size() != 0) begin
          exp_b = exp_tx_q.pop_front();
        end else begin
          exp_b = 8'h00;
        end
        bad = 0;
        for (int i = 1; i < bit_cyc; i++) begin
          @(negedge clk_i);
          if (txd_o !== 1'b0) bad++;
        end
        check($sformatf("tx_start_bit_%0h", exp_b), bad, 32'd0);
        for (int b = 0; b < DW; b++) begin
          bad = 0;
          for (int i = 0; i < bit_cyc; i++) begin
            @(negedge clk_i);
            if (txd_o !== exp_b[b]) bad++;
          end
          check($sformatf("tx_bit%0d_of_%0h", b, exp_b), bad, 32'd0);
        end
        bad = 0;
        for (int i = 0; i < bit_cyc; i++) begin
          @(negedge clk_i);
          if (txd_o !== 1'b1) bad++;
        end
        check($sformatf("tx_stop_bit_%0h", exp_b), bad, 32'd0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : main
    int bad;
    logic [7:0] d;
    rst_ni     = 1'b0;
    rxd_i      = 1'b1;
    prescale_i = 16'd1;
    echo_en_i  = 1'b0;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    clr_err_i  = 1'b0;
    bit_cyc    = 8;
    cycles(3);
    check("rst_txd", {31'd0, txd_o}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_level", {27'd0, fifo_level_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    rst_ni = 1'b1;
    cycles(1);
    check("tx_ready_after_release", {31'd0, tx_ready_o}, 32'd1);
    cycles(3);
    mon_en = 1'b1;

    // Host-mode receive of A5 at prescale 1.
    exp_rx_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    check("level_after_a5", {27'd0, fifo_level_o}, 32'd1);
    read_rx();
    check("level_after_pop", {27'd0, fifo_level_o}, 32'd0);

    // Host-mode transmit of 3C, checked cycle by cycle by the monitor.
    exp_tx_q.push_back(8'h3C);
    send_tx(8'h3C);
    wait_tx_drain(300);

    // Echo mode at prescale 2.
    echo_en_i  = 1'b1;
    prescale_i = 16'd2;
    bit_cyc    = 16;
    cycles(1);
    check("echo_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    exp_tx_q.push_back(8'h55);
    exp_tx_q.push_back(8'h0F);
    send_rx(8'h55, 1'b1);
    check("echo_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    send_rx(8'h0F, 1'b1);
    wait_tx_drain(800);
    check("echo_level", {27'd0, fifo_level_o}, 32'd0);
    echo_en_i  = 1'b0;
    prescale_i = 16'd1;
    bit_cyc    = 8;
    cycles(2);

    // Fill past capacity with the host not reading.
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 5);
      if (i < 16) exp_rx_q.push_back(d);
      send_rx(d, 1'b1);
    end
    check("full_level", {27'd0, fifo_level_o}, 32'd16);
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    cycles(3);
    check("rx_hold", {24'd0, rx_data_o}, {24'd0, exp_rx_q[0]});
    for (int i = 0; i < 16; i++) read_rx();
    check("drained_level", {27'd0, fifo_level_o}, 32'd0);
    clr_err_i = 1'b1;
    cycles(1);
    clr_err_i = 1'b0;
    check("overrun_cleared", {31'd0, overrun_o}, 32'd0);

    // Stop bit held low.
    send_rx(8'h77, 1'b0);
    check("frame_err_set", {31'd0, frame_err_o}, 32'd1);
    check("frame_err_level", {27'd0, fifo_level_o}, 32'd0);
    clr_err_i = 1'b1;
    cycles(1);
    clr_err_i = 1'b0;
    check("frame_err_cleared", {31'd0, frame_err_o}, 32'd0);

    // Full duplex: transmit and receive at the same time.
    exp_tx_q.push_back(8'h81);
    exp_rx_q.push_back(8'h42);
    fork
      send_tx(8'h81);
      send_rx(8'h42, 1'b1);
    join
    read_rx();
    wait_tx_drain(300);

    // Reset during TX data bit 3, with state left in the FIFO and error flag.
    send_rx(8'h12, 1'b1);
    send_rx(8'h34, 1'b0);
    check("pre_reset_level", {27'd0, fifo_level_o}, 32'd1);
    check("pre_reset_frame_err", {31'd0, frame_err_o}, 32'd1);
    mon_en = 1'b0;
    send_tx(8'h00);
    cycles(36);
    check("tx_bit3_low", {31'd0, txd_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("midreset_txd", {31'd0, txd_o}, 32'd1);
    check("midreset_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    check("midreset_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("midreset_level", {27'd0, fifo_level_o}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err_o}, 32'd0);
    cycles(2);
    rst_ni = 1'b1;
    cycles(1);
    check("ready_after_midreset", {31'd0, tx_ready_o}, 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (txd_o !== 1'b1) bad++;
    end
    check("no_residual_tx", bad, 32'd0);

    check("rx_sb_empty", exp_rx_q.size(), 32'd0);
    check("tx_sb_empty", exp_tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
